// File: rtl/cpu_pkg.sv
// Shared CPU definitions: sequencer phase states, opcode map and a legality check.
// The instruction decoder uses the same opcode constants.
package cpu_pkg;

  typedef enum logic [3:0] {
    S_FETCH = 4'b0001,
    S_EXEC1 = 4'b0010,
    S_EXEC2 = 4'b0100,
    S_HALT  = 4'b1000
  } state_t;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_STA = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_JMP = 4'b0100;
  localparam logic [3:0] OP_JZ  = 4'b0101;
  localparam logic [3:0] OP_JN  = 4'b0110;
  localparam logic [3:0] OP_STP = 4'b0111;
  localparam logic [3:0] OP_LDI = 4'b1000;
  localparam logic [3:0] OP_SHL = 4'b1010;
  localparam logic [3:0] OP_ASR = 4'b1011;

  // 1001 and 11xx are unassigned and stop the core.
  function automatic logic is_legal_op(input logic [3:0] op);
    case (op)
      4'b1001, 4'b1100, 4'b1101, 4'b1110, 4'b1111: return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector: registers D and flags the cycle where it goes 0->1.
module edge_detect (
  input  logic CLK,
  input  logic RESETn,
  input  logic D,
  output logic RISE
);

  logic d_q;

  always_ff @(posedge CLK) begin
    if (!RESETn) d_q <= 1'b0;
    else         d_q <= D;
  end

  assign RISE = D & ~d_q;

endmodule

// File: rtl/cpu_sequencer.sv
// CPU phase sequencer: FETCH/EXEC1/EXEC2 strobes, instruction register,
// halt on STP or illegal opcode, free-run / single-step, retired counter.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int OPCODE_W = 4,
  parameter int ADDR_W   = 12,
  parameter int COUNT_W  = 16
) (
  input  logic                       CLK,
  input  logic                       RESETn,
  input  logic                       RUN,
  input  logic                       STEP,
  input  logic [OPCODE_W+ADDR_W-1:0] MEM_Q,
  input  logic                       EXTRA,
  output logic                       FETCH,
  output logic                       EXEC1,
  output logic                       EXEC2,
  output logic [OPCODE_W-1:0]        IR,
  output logic [ADDR_W-1:0]          IR_ADDR,
  output logic                       HALTED,
  output logic                       ILLEGAL,
  output logic [COUNT_W-1:0]         INSTR_COUNT
);

  state_t state, state_nxt;
  logic   step_rise, step_pending, go;

  edge_detect u_step_edge (
    .CLK    (CLK),
    .RESETn (RESETn),
    .D      (STEP),
    .RISE   (step_rise)
  );

  assign go = RUN | step_pending;

  always_comb begin
    state_nxt = state;
    FETCH     = 1'b0;
    EXEC1     = 1'b0;
    EXEC2     = 1'b0;
    HALTED    = 1'b0;
    case (state)
      S_FETCH: if (go) begin
        FETCH     = 1'b1;
        state_nxt = S_EXEC1;
      end
      S_EXEC1: begin
        EXEC1 = 1'b1;
        if (IR == OP_STP || !is_legal_op(IR)) state_nxt = S_HALT;
        else if (EXTRA)                       state_nxt = S_EXEC2;
        else                                  state_nxt = S_FETCH;
      end
      S_EXEC2: begin
        EXEC2     = 1'b1;
        state_nxt = S_FETCH;
      end
      S_HALT:  HALTED = 1'b1;
      default: state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      state        <= S_FETCH;
      IR           <= '0;
      IR_ADDR      <= '0;
      ILLEGAL      <= 1'b0;
      INSTR_COUNT  <= '0;
      step_pending <= 1'b0;
    end else begin
      state <= state_nxt;
      if (FETCH) begin
        IR          <= MEM_Q[OPCODE_W+ADDR_W-1:ADDR_W];
        IR_ADDR     <= MEM_Q[ADDR_W-1:0];
        INSTR_COUNT <= INSTR_COUNT + COUNT_W'(1);
      end
      if (EXEC1 && IR != OP_STP && !is_legal_op(IR)) ILLEGAL <= 1'b1;
      // A rise coinciding with a taken fetch re-arms for the next instruction.
      if (state != S_HALT) begin
        if (FETCH)          step_pending <= step_rise;
        else if (step_rise) step_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: directed scenarios plus random
// stimulus against an instruction-level reference model.
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        RESETn, RUN, STEP, EXTRA;
  logic [15:0] MEM_Q;
  logic        FETCH, EXEC1, EXEC2, HALTED, ILLEGAL;
  logic [3:0]  IR;
  logic [11:0] IR_ADDR;
  logic [15:0] INSTR_COUNT;

  cpu_sequencer dut (
    .CLK(clk), .RESETn(RESETn), .RUN(RUN), .STEP(STEP), .MEM_Q(MEM_Q), .EXTRA(EXTRA),
    .FETCH(FETCH), .EXEC1(EXEC1), .EXEC2(EXEC2), .IR(IR), .IR_ADDR(IR_ADDR),
    .HALTED(HALTED), .ILLEGAL(ILLEGAL), .INSTR_COUNT(INSTR_COUNT)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic f, e1, e2, h, il;
    logic [3:0]  ir;
    logic [11:0] addr;
    logic [15:0] cnt;
  } obs_t;

  int n_cmp = 0, n_fail = 0;
  obs_t act, exp;

  // Reference model: instruction-level view with a queue of pending execute phases.
  int          ph_q[$];            // 1 = EXEC1 due, 2 = EXEC2 due
  logic        m_halt = 0, m_ill = 0, m_pend = 0, m_stepd = 0;
  logic [3:0]  m_ir = 0;
  logic [11:0] m_addr = 0;
  logic [15:0] m_cnt = 0;

  function automatic logic bad_op(input logic [3:0] op);
    return op == 4'h9 || op >= 4'hC;
  endfunction

  // Advance one clock: sample DUT and model at the negedge, then update the model.
  task automatic cyc();
    logic rise;
    obs_t e;
    @(negedge clk);
    rise = STEP & ~m_stepd;
    e = '0;
    e.h = m_halt; e.il = m_ill; e.ir = m_ir; e.addr = m_addr; e.cnt = m_cnt;
    if (!m_halt) begin
      if (ph_q.size() > 0) begin
        if (ph_q[0] == 1) e.e1 = 1'b1; else e.e2 = 1'b1;
      end else e.f = RUN | m_pend;
    end
    exp = e;
    act = {FETCH, EXEC1, EXEC2, HALTED, ILLEGAL, IR, IR_ADDR, INSTR_COUNT};
    if (!RESETn) begin
      ph_q.delete();
      m_halt = 0; m_ill = 0; m_pend = 0; m_stepd = 0;
      m_ir = 0; m_addr = 0; m_cnt = 0;
    end else begin
      if (!m_halt) begin
        if (e.e1) begin
          void'(ph_q.pop_front());
          if (m_ir == 4'h7) m_halt = 1;
          else if (bad_op(m_ir)) begin m_halt = 1; m_ill = 1; end
          else if (EXTRA) ph_q.push_back(2);
        end else if (e.e2) void'(ph_q.pop_front());
        else if (e.f) begin
          m_ir = MEM_Q[15:12]; m_addr = MEM_Q[11:0]; m_cnt = m_cnt + 16'd1;
          ph_q.push_back(1);
        end
        if (e.f) m_pend = rise;
        else if (rise) m_pend = 1;
      end
      m_stepd = STEP;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    RESETn = 0; cyc(); RESETn = 1;
  endtask

  task automatic test_reset();
    RESETn = 0; RUN = 0; STEP = 0; EXTRA = 0; MEM_Q = 16'h0000;
    cyc(); cyc();
    n_cmp++;
    if (act !== obs_t'(0)) begin n_fail++; $display("FAIL reset_state: got %h want 0", act); end
    RESETn = 1;
    for (int i = 0; i < 3; i++) begin
      cyc(); n_cmp++;
      if (act !== exp) begin n_fail++; $display("FAIL reset_idle: got %h want %h", act, exp); end
    end
  endtask

  task automatic test_extra();
    obs_t seq[4];
    RUN = 0; do_reset();
    RUN = 1; MEM_Q = 16'h0005; EXTRA = 1;
    for (int i = 0; i < 4; i++) begin
      cyc(); seq[i] = act; n_cmp++;
      if (act !== exp) begin n_fail++; $display("FAIL extra_model c%0d: got %h want %h", i, act, exp); end
    end
    n_cmp++;
    if ({seq[0].f, seq[1].e1, seq[2].e2, seq[3].f} !== 4'hF || seq[1].f || seq[2].e1 || seq[3].e2) begin
      n_fail++; $display("FAIL extra_seq: got %b%b%b%b", seq[0].f, seq[1].e1, seq[2].e2, seq[3].f);
    end
    n_cmp++;
    if ({seq[1].ir, seq[1].addr, seq[1].cnt} !== {4'h0, 12'h005, 16'd1}) begin
      n_fail++; $display("FAIL extra_ir: got %h/%h/%0d want 0/005/1", seq[1].ir, seq[1].addr, seq[1].cnt);
    end
  endtask

  task automatic test_back_to_back();
    int fcnt = 0;
    RUN = 0; do_reset();
    RUN = 1; MEM_Q = 16'h8123; EXTRA = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(); n_cmp++;
      if (act !== exp) begin n_fail++; $display("FAIL b2b_model c%0d: got %h want %h", i, act, exp); end
      if (act.e2) begin n_cmp++; n_fail++; $display("FAIL b2b_no_exec2: got EXEC2=1 want 0"); end
      if (act.f) fcnt++;
    end
    n_cmp++;
    if (fcnt != 5 || act.cnt !== 16'd5) begin
      n_fail++; $display("FAIL b2b_rate: got %0d fetches cnt %0d want 5/5", fcnt, act.cnt);
    end
  endtask

  task automatic test_stp();
    int strobes = 0;
    RUN = 0; do_reset();
    RUN = 1; MEM_Q = 16'h7000; EXTRA = 1;
    cyc(); cyc();
    for (int i = 0; i < 20; i++) begin
      cyc(); strobes += act.f + act.e1 + act.e2; n_cmp++;
      if (act !== exp) begin n_fail++; $display("FAIL stp_model c%0d: got %h want %h", i, act, exp); end
    end
    n_cmp++;
    if (strobes != 0 || act.h !== 1'b1 || act.il !== 1'b0 || act.cnt !== 16'd1) begin
      n_fail++; $display("FAIL stp_halt: got strobes %0d h %b il %b cnt %0d want 0/1/0/1", strobes, act.h, act.il, act.cnt);
    end
  endtask

  task automatic test_illegal();
    RUN = 0; do_reset();
    RUN = 1; MEM_Q = 16'hC000; EXTRA = 0;
    for (int i = 0; i < 5; i++) cyc();
    n_cmp++;
    if (act.h !== 1'b1 || act.il !== 1'b1) begin
      n_fail++; $display("FAIL illegal_halt: got h %b il %b want 1/1", act.h, act.il);
    end
    RESETn = 0; cyc(); RESETn = 1; MEM_Q = 16'h0000;
    cyc(); n_cmp++;
    if (act.h !== 1'b0 || act.il !== 1'b0 || act.f !== 1'b1) begin
      n_fail++; $display("FAIL illegal_clear: got h %b il %b f %b want 0/0/1", act.h, act.il, act.f);
    end
  endtask

  task automatic test_step();
    int fcnt = 0;
    RUN = 0; STEP = 0; do_reset();
    MEM_Q = 16'h8001; EXTRA = 0;
    for (int p = 0; p < 2; p++) begin
      STEP = 1; cyc(); n_cmp++;
      if (act !== exp) begin n_fail++; $display("FAIL step_model: got %h want %h", act, exp); end
      if (act.f) fcnt++;
      STEP = 0;
      for (int i = 0; i < 4; i++) begin
        cyc(); n_cmp++; if (act.f) fcnt++;
        if (act !== exp) begin n_fail++; $display("FAIL step_model: got %h want %h", act, exp); end
      end
    end
    for (int i = 0; i < 8; i++) begin cyc(); if (act.f) fcnt++; end
    n_cmp++;
    if (fcnt != 2 || act.cnt !== 16'd2) begin
      n_fail++; $display("FAIL step_two: got %0d fetches cnt %0d want 2/2", fcnt, act.cnt);
    end
    fcnt = 0; do_reset();
    STEP = 1;
    for (int i = 0; i < 15; i++) begin cyc(); if (act.f) fcnt++; end
    STEP = 0; n_cmp++;
    if (fcnt != 1 || act.cnt !== 16'd1) begin
      n_fail++; $display("FAIL step_held: got %0d fetches cnt %0d want 1/1", fcnt, act.cnt);
    end
  endtask

  task automatic test_reset_mid();
    RUN = 0; do_reset();
    RUN = 1; MEM_Q = 16'h2abc; EXTRA = 1;
    cyc(); cyc();
    RESETn = 0; cyc(); RESETn = 1;
    n_cmp++;
    if (act.e2 !== 1'b1) begin n_fail++; $display("FAIL mid_in_exec2: got EXEC2 %b want 1", act.e2); end
    MEM_Q = 16'h3111; EXTRA = 0;
    cyc(); n_cmp++;
    if ({act.f, act.e2, act.ir, act.cnt} !== {1'b1, 1'b0, 4'h0, 16'd0}) begin
      n_fail++; $display("FAIL mid_after: got f %b e2 %b ir %h cnt %0d want 1/0/0/0", act.f, act.e2, act.ir, act.cnt);
    end
    cyc(); n_cmp++;
    if (act !== exp || act.e2) begin n_fail++; $display("FAIL mid_next: got %h want %h", act, exp); end
  endtask

  task automatic test_random();
    RUN = 0; do_reset();
    for (int i = 0; i < 600; i++) begin
      RESETn = ($urandom_range(0, 49) != 0);
      RUN    = ($urandom_range(0, 3) != 0);
      STEP   = $urandom_range(0, 1);
      EXTRA  = $urandom_range(0, 1);
      MEM_Q  = {($urandom_range(0, 11) == 0) ? 4'($urandom_range(7, 15)) : 4'($urandom_range(0, 8)),
                12'($urandom)};
      cyc(); n_cmp++;
      if (act !== exp) begin n_fail++; $display("FAIL random c%0d: got %h want %h", i, act, exp); end
    end
    RESETn = 1;
  endtask

  initial begin
    RESETn = 0; RUN = 0; STEP = 0; EXTRA = 0; MEM_Q = 16'h0;
    @(posedge clk); #1;
    test_reset();
    test_extra();
    test_back_to_back();
    test_stp();
    test_illegal();
    test_step();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
